// File: rtl/fetch_queue_unit_pkg.sv
// Shared definitions for the fetch stage: RISC-V opcodes, FSM states and
// immediate extraction helpers.
package fetch_queue_unit_pkg;

    localparam logic [6:0] JAL_TYPE    = 7'b1101111;
    localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    function automatic logic [20:0] j_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [12:0] b_imm(input logic [31:0] inst);
        return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue_unit_chk.sv
// Protocol checker: a response must never be enqueued into a full queue,
// which would mean the slot-reservation rule was broken.
module fetch_queue_unit_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          enq,
    input logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    enq_into_full_a: assert property (@(posedge clk) disable iff (rst) !(enq && (count == DEPTH_C)));

endmodule

// File: rtl/fetch_queue_unit_inst_queue.sv
// Synchronous circular FIFO holding {inst, pc, jump} fetch entries.
// Dequeue from an empty queue is ignored; clear empties it in one cycle.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  logic [W-1:0]             enq_inst,
    input  logic [W-1:0]             enq_pc,
    input  logic                     enq_jump,
    input  logic                     deq,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head_inst,
    output logic [W-1:0]             head_pc,
    output logic                     head_jump
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};

    logic [W-1:0]  inst_mem_r [DEPTH];
    logic [W-1:0]  pc_mem_r   [DEPTH];
    logic          jump_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          deq_fire_s;

    assign deq_fire_s = deq && (count_r != {CW{1'b0}});

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            if (deq_fire_s) rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            case ({enq, deq_fire_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed while the slot is occupied
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem_r[wr_ptr_r] <= enq_inst;
            pc_mem_r[wr_ptr_r]   <= enq_pc;
            jump_mem_r[wr_ptr_r] <= enq_jump;
        end
    end

    assign count     = count_r;
    assign head_inst = inst_mem_r[rd_ptr_r];
    assign head_pc   = pc_mem_r[rd_ptr_r];
    assign head_jump = jump_mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: issues one i-cache request at a time, predicts the next PC per
// returned word and buffers fetched words in a queue for the dispatcher.
import fetch_queue_unit_pkg::*;

module fetch_queue_unit #(
    parameter int              IQ_DEPTH = 8,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            icache_req,
    output logic [PC_W-1:0] icache_pc,
    input  logic            icache_valid,
    input  logic [PC_W-1:0] icache_inst,
    output logic [PC_W-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic            deq_ready,
    output logic            out_valid,
    output logic [PC_W-1:0] out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic            out_jump
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(IQ_DEPTH);
    localparam logic [CW-1:0]   ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] STEP_C  = {{(PC_W-3){1'b0}}, 3'b100};

    fetch_state_t    state_r, state_nxt_s;
    logic [PC_W-1:0] pc_r, pc_nxt_s;
    logic [PC_W-1:0] icache_pc_r, icache_pc_nxt_s;
    logic            icache_req_r, icache_req_nxt_s;
    logic [PC_W-1:0] next_pc_s;
    logic            jump_s, enq_s, deq_s, clear_s, out_valid_s;
    logic [CW-1:0]   count_s, count_after_s;
    logic [PC_W-1:0] head_inst_s, head_pc_s;
    logic            head_jump_s;
    logic [20:0]     j_imm_s;
    logic [12:0]     b_imm_s;

    assign j_imm_s       = j_imm(icache_inst[31:0]);
    assign b_imm_s       = b_imm(icache_inst[31:0]);
    assign out_valid_s   = (count_s != {CW{1'b0}});
    assign count_after_s = count_s + ONE_C - {{(CW-1){1'b0}}, deq_s};

    // Next-PC and jump flag for the word currently returned by the cache
    always_comb begin
        next_pc_s = icache_pc_r + STEP_C;
        jump_s    = 1'b0;
        case (icache_inst[6:0])
            JAL_TYPE: begin
                next_pc_s = icache_pc_r + {{(PC_W-21){j_imm_s[20]}}, j_imm_s};
                jump_s    = 1'b1;
            end
            BRANCH_TYPE: begin
                if (pred_taken) begin
                    next_pc_s = icache_pc_r + {{(PC_W-13){b_imm_s[12]}}, b_imm_s};
                    jump_s    = 1'b1;
                end else begin
                    next_pc_s = icache_pc_r + STEP_C;
                    jump_s    = 1'b0;
                end
            end
            default: begin
                next_pc_s = icache_pc_r + STEP_C;
                jump_s    = 1'b0;
            end
        endcase
    end

    // Request FSM with priority rdy-hold > flush > normal fetch
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        icache_pc_nxt_s  = icache_pc_r;
        icache_req_nxt_s = icache_req_r;
        enq_s            = 1'b0;
        deq_s            = 1'b0;
        clear_s          = 1'b0;
        if (!rdy) begin
            state_nxt_s = state_r;
        end else if (flush) begin
            pc_nxt_s         = flush_pc;
            icache_req_nxt_s = 1'b0;
            clear_s          = 1'b1;
            case (state_r)
                // An outstanding request must still be drained unless it lands now
                WAIT:    state_nxt_s = icache_valid ? IDLE : DROP;
                default: state_nxt_s = state_r;
            endcase
        end else begin
            deq_s = out_valid_s && deq_ready;
            case (state_r)
                IDLE: begin
                    if (count_s < DEPTH_C) begin
                        icache_req_nxt_s = 1'b1;
                        icache_pc_nxt_s  = pc_r;
                        state_nxt_s      = WAIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                WAIT: begin
                    if (icache_valid) begin
                        enq_s    = 1'b1;
                        pc_nxt_s = next_pc_s;
                        if (count_after_s < DEPTH_C) begin
                            icache_pc_nxt_s = next_pc_s;
                            state_nxt_s     = WAIT;
                        end else begin
                            icache_req_nxt_s = 1'b0;
                            state_nxt_s      = IDLE;
                        end
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                DROP: begin
                    if (icache_valid) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, PC and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            icache_pc_r  <= RESET_PC;
            icache_req_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            icache_pc_r  <= icache_pc_nxt_s;
            icache_req_r <= icache_req_nxt_s;
        end
    end

    inst_queue #(
        .DEPTH (IQ_DEPTH),
        .W     (PC_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq_s),
        .enq_inst  (icache_inst),
        .enq_pc    (icache_pc_r),
        .enq_jump  (jump_s),
        .deq       (deq_s),
        .clear     (clear_s),
        .count     (count_s),
        .head_inst (head_inst_s),
        .head_pc   (head_pc_s),
        .head_jump (head_jump_s)
    );

    fetch_queue_unit_chk #(
        .DEPTH (IQ_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq_s),
        .count (count_s)
    );

    // Head fields read as zero while the queue is empty
    always_comb begin
        if (out_valid_s) begin
            out_inst = head_inst_s;
            out_pc   = head_pc_s;
            out_jump = head_jump_s;
        end else begin
            out_inst = {PC_W{1'b0}};
            out_pc   = {PC_W{1'b0}};
            out_jump = 1'b0;
        end
    end

    assign icache_req = icache_req_r;
    assign icache_pc  = icache_pc_r;
    assign pred_pc    = icache_pc_r;
    assign out_valid  = out_valid_s;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit: sequential fetch, JAL,
// predicted branches, queue-full stall, flush cases and rdy freeze.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, icache_valid, pred_taken, deq_ready;
    logic [31:0] flush_pc, icache_inst;
    logic        icache_req, out_valid, out_jump;
    logic [31:0] icache_pc, pred_pc, out_inst, out_pc;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] ADDI     = 32'h0000_0013;
    localparam logic [31:0] JAL_P20  = 32'h0200_006F;
    localparam logic [31:0] JAL_P10  = 32'h0100_006F;
    localparam logic [31:0] JAL_P08  = 32'h0080_006F;
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .icache_req   (icache_req),
        .icache_pc    (icache_pc),
        .icache_valid (icache_valid),
        .icache_inst  (icache_inst),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .deq_ready    (deq_ready),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_jump     (out_jump)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic [31:0] inst, input logic taken);
        icache_valid = 1'b1;
        icache_inst  = inst;
        pred_taken   = taken;
        tick();
        icache_valid = 1'b0;
        pred_taken   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = 32'h0;
        icache_valid = 1'b0; icache_inst = 32'h0; pred_taken = 1'b0; deq_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req", {31'd0, icache_req}, 32'd0);
        chk("rst_ipc", icache_pc, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_jump", {31'd0, out_jump}, 32'd0);

        // 1: sequential addi fetch at 0,4,8
        tick();
        chk("t1_req", {31'd0, icache_req}, 32'd1);
        chk("t1_ipc0", icache_pc, 32'h0);
        chk("t1_pred_pc", pred_pc, 32'h0);
        resp(ADDI, 1'b0);
        chk("t1_ipc4", icache_pc, 32'h4);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_head_inst", out_inst, ADDI);
        resp(ADDI, 1'b0);
        resp(ADDI, 1'b0);
        chk("t1_ipc_c", icache_pc, 32'hC);
        chk("t1_head0", out_pc, 32'h0);
        chk("t1_jump0", {31'd0, out_jump}, 32'd0);
        deq_ready = 1'b1;
        tick();
        chk("t1_head4", out_pc, 32'h4);
        tick();
        chk("t1_head8", out_pc, 32'h8);
        tick();
        deq_ready = 1'b0;
        chk("t1_empty", {31'd0, out_valid}, 32'd0);
        chk("t1_empty_pc", out_pc, 32'h0);

        // 2: JAL at 0x10 with +0x20
        resp(ADDI, 1'b0);
        chk("t2_ipc10", icache_pc, 32'h10);
        resp(JAL_P20, 1'b0);
        chk("t2_jal_target", icache_pc, 32'h30);
        chk("t2_head_c", out_pc, 32'hC);
        deq_ready = 1'b1;
        tick();
        chk("t2_head_jal_pc", out_pc, 32'h10);
        chk("t2_head_jal_jump", {31'd0, out_jump}, 32'd1);
        chk("t2_head_jal_inst", out_inst, JAL_P20);
        tick();
        deq_ready = 1'b0;
        chk("t2_empty", {31'd0, out_valid}, 32'd0);

        // 3: BEQ -8 at 0x40, taken then not taken
        resp(JAL_P10, 1'b0);
        chk("t3_ipc40a", icache_pc, 32'h40);
        resp(BEQ_M8, 1'b1);
        chk("t3_taken", icache_pc, 32'h38);
        resp(JAL_P08, 1'b0);
        chk("t3_ipc40b", icache_pc, 32'h40);
        resp(BEQ_M8, 1'b0);
        chk("t3_not_taken", icache_pc, 32'h44);
        chk("t3_q0_pc", out_pc, 32'h30);
        chk("t3_q0_jump", {31'd0, out_jump}, 32'd1);
        deq_ready = 1'b1;
        tick();
        chk("t3_q1_pc", out_pc, 32'h40);
        chk("t3_q1_jump", {31'd0, out_jump}, 32'd1);
        tick();
        chk("t3_q2_pc", out_pc, 32'h38);
        tick();
        chk("t3_q3_pc", out_pc, 32'h40);
        chk("t3_q3_jump", {31'd0, out_jump}, 32'd0);
        tick();
        deq_ready = 1'b0;
        chk("t3_empty", {31'd0, out_valid}, 32'd0);

        // 4: fill the queue without dequeue
        for (int i = 0; i < 8; i++) resp(ADDI, 1'b0);
        chk("t4_full_req", {31'd0, icache_req}, 32'd0);
        chk("t4_full_ipc", icache_pc, 32'h60);
        chk("t4_full_head", out_pc, 32'h44);
        tick();
        tick();
        chk("t4_idle_req", {31'd0, icache_req}, 32'd0);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        chk("t4_deq_req", {31'd0, icache_req}, 32'd0);
        chk("t4_deq_head", out_pc, 32'h48);
        tick();
        chk("t4_rereq", {31'd0, icache_req}, 32'd1);
        chk("t4_rereq_ipc", icache_pc, 32'h64);
        deq_ready = 1'b1;
        repeat (7) tick();
        deq_ready = 1'b0;
        chk("t4_drained", {31'd0, out_valid}, 32'd0);

        // 5: flush while waiting, response arrives 2 cycles later
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        chk("t5_drop_req", {31'd0, icache_req}, 32'd0);
        tick();
        resp(ADDI, 1'b0);
        chk("t5_discard", {31'd0, out_valid}, 32'd0);
        chk("t5_idle_req", {31'd0, icache_req}, 32'd0);
        tick();
        chk("t5_req", {31'd0, icache_req}, 32'd1);
        chk("t5_ipc", icache_pc, 32'h100);

        // 6: flush coincident with a response, 3 entries queued
        resp(ADDI, 1'b0);
        resp(ADDI, 1'b0);
        resp(ADDI, 1'b0);
        chk("t6_ipc", icache_pc, 32'h10C);
        chk("t6_head", out_pc, 32'h100);
        flush = 1'b1; flush_pc = 32'h200; deq_ready = 1'b1;
        resp(ADDI, 1'b0);
        flush = 1'b0; deq_ready = 1'b0;
        chk("t6_cleared", {31'd0, out_valid}, 32'd0);
        chk("t6_req_off", {31'd0, icache_req}, 32'd0);
        tick();
        chk("t6_req", {31'd0, icache_req}, 32'd1);
        chk("t6_ipc200", icache_pc, 32'h200);
        chk("t6_no_enq", {31'd0, out_valid}, 32'd0);

        // 7: rdy low for 5 cycles mid-WAIT freezes everything
        resp(ADDI, 1'b0);
        chk("t7_ipc", icache_pc, 32'h204);
        rdy = 1'b0; icache_valid = 1'b1; icache_inst = JAL_P20; deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t7_frz_req", {31'd0, icache_req}, 32'd1);
            chk("t7_frz_ipc", icache_pc, 32'h204);
            chk("t7_frz_head", out_pc, 32'h200);
        end
        rdy = 1'b1; icache_valid = 1'b0; deq_ready = 1'b0;
        tick();
        chk("t7_after_ipc", icache_pc, 32'h204);
        chk("t7_after_valid", {31'd0, out_valid}, 32'd1);
        resp(ADDI, 1'b0);
        chk("t7_resume_ipc", icache_pc, 32'h208);
        chk("t7_resume_head", out_pc, 32'h200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
